rb_window_sequencer: RTL and testbench
======================================

Name: rb_window_sequencer

Overview:
- Sequences the row-buffer (RB) datapath for neighbourhood image processing.
- Streams an IMG_W x IMG_H image from external pixel memory in raster order and writes each row into one of K circular BRAM row buffers.
- In the same cycle it reads the matching column from the other K-1 buffers, so the datapath can assemble one K-tall window column per cycle.
- Sits between the top-level start/complete handshake and the external-memory/BRAM address and enable paths, in place of hand-wired enables.

Parameters:
- IMG_W, 256, pixels per row (>= 2)
- IMG_H, 256, rows per image (>= K)
- K, 3, window height = number of physical row buffers (2..4)
- COL_W, $clog2(IMG_W), BRAM column address width
- EXT_AW, $clog2(IMG_W*IMG_H), external memory address width
- ROW_SW, $clog2(K) (min 1), physical row index width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- stall  in  1  freeze all counters and pipeline stages while high
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at frame end
- ext_rd_en  out  1  external memory read strobe (read latency 1)
- ext_rd_addr  out  EXT_AW  raster pixel address
- bram_we  out  K  one-hot write enable of the target row buffer
- bram_wr_addr  out  COL_W  column written
- bram_rd_en  out  1  read strobe to all non-target buffers (read latency 1)
- bram_rd_addr  out  COL_W  column read
- row_oldest  out  ROW_SW  physical index of the oldest row, aligned with col_valid
- col_valid  out  1  window column available on the datapath this cycle
- col_first  out  1  with col_valid: column 0
- col_last  out  1  with col_valid: column IMG_W-1

Behaviour:
- Reset (any state, including mid-frame): state=IDLE; every output 0; all counters and pipeline stages cleared. In-flight data is discarded and no done pulse is produced.
- FSM states:
  - IDLE: on start, go to RUN; busy rises next cycle.
  - RUN: issue one read per non-stalled cycle. After issuing the last pixel (row IMG_H-1, col IMG_W-1), go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: pulse done for one cycle, drop busy, return to IDLE.
- start while busy is ignored. start held high in IDLE restarts a frame after DONE.
- Counters:
  - col counts 0..IMG_W-1, then wraps to 0 and increments row.
  - wr_row is a mod-K rotating counter advanced at each row wrap. No division or modulo operator is used.
  - ext_rd_addr is a running counter, not row*IMG_W+col.
- Pipeline (no stall):
  - S0 (cycle n): ext_rd_en=1, ext_rd_addr=pixel index.
  - S1 (n+1): ext data arrives; bram_we=onehot(wr_row), bram_wr_addr=col; bram_rd_en=1, bram_rd_addr=col, but only when row >= K-1.
  - S2 (n+2): col_valid=1 for rows >= K-1; col_first/col_last from the S1 column; row_oldest=(wr_row+1) mod K as captured at S1.
- Rows 0..K-2 only fill buffers and never assert col_valid.
- Read and write of the same column happen in the same cycle on different physical buffers, so there is no read-during-write conflict.
- stall=1:
  - ext_rd_en, bram_we, bram_rd_en and col_valid are 0 that cycle.
  - All counters, pipeline registers and FSM state hold.
  - Processing resumes exactly where it left off.
  - The datapath must not consume external/BRAM data during stall (same timing contract).
- Totals per frame: IMG_W*IMG_H reads and IMG_W*(IMG_H-K+1) col_valid pulses.
- Done timing: done is asserted 1 cycle after the final col_valid, excluding stalls.
- Unused outputs are 0 in IDLE and DONE.

Decomposition:
- Shared package rb_pkg holds:
  - the FSM state encoding (IDLE, RUN, DRAIN, DONE);
  - default IMG_W/IMG_H/K;
  - the helper constant for read/BRAM latency (1).
- One natural sub-module, rb_row_rotator: mod-K wr_row counter plus row_oldest computation and the one-hot decode, shared with future multi-kernel variants.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, K=3.
- Nominal frame: start at cycle 0, no stall.
  - ext_rd_en high cycles 1..48 with addr 0..47.
  - First col_valid at cycle 19 with col_first=1, row_oldest=0.
  - 32 col_valid pulses in total; last at cycle 50 with col_last=1.
  - done=1 at cycle 51 only; busy high cycles 1..51.
- Row rotation:
  - Output row 2: bram_we=3'b100, row_oldest=0.
  - Row 3: bram_we=3'b001, row_oldest=1.
  - Row 5: bram_we=3'b100, row_oldest=0.
  - bram_rd_en low for all of rows 0-1.
- Stall: stall=1 for cycles 20..24.
  - All strobes 0 in those cycles and addresses held.
  - Counts unchanged at 48 reads and 32 col_valid pulses; done shifts to cycle 56.
- start while busy: pulse start at cycle 30 → ignored; done still at cycle 51; no second frame.
- Reset mid-frame: rst at cycle 25 → next cycle all outputs 0 and state IDLE, with no done pulse. A new start then reproduces the nominal-frame timing from the new start cycle.
- Back-to-back frames with start held high: the second frame's first read issues 2 cycles after the first frame's done.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the row-buffer window sequencer: FSM encoding,
// default image geometry and the external-memory/BRAM read latency.
package rb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_e;

  localparam int RB_IMG_W  = 256;
  localparam int RB_IMG_H  = 256;
  localparam int RB_K      = 3;
  localparam int RB_RD_LAT = 1;

endpackage

// File: rtl/rb_row_rotator.sv
// Mod-K rotating write-row pointer with one-hot buffer select and the
// physical index of the oldest row (the one overwritten next).
module rb_row_rotator #(
  parameter int K      = 3,
  parameter int ROW_SW = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [K-1:0]      o_onehot,
  output logic [ROW_SW-1:0] o_oldest
);

  localparam logic [ROW_SW-1:0] ROW_LAST = ROW_SW'(K - 1);

  logic [ROW_SW-1:0] r_wr_row;

  // NOTE: synchronous reset and non-blocking assignments for all state.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_row <= '0;
    end else if (i_advance) begin
      r_wr_row <= (r_wr_row == ROW_LAST) ? '0 : r_wr_row + ROW_SW'(1);
    end
  end

  // Wrap by compare rather than modulo; K need not be a power of two.
  always_comb begin
    o_oldest = (r_wr_row == ROW_LAST) ? '0 : r_wr_row + ROW_SW'(1);
    o_onehot = '0;
    for (int i = 0; i < K; i++) begin
      o_onehot[i] = (r_wr_row == ROW_SW'(i));
    end
  end

endmodule

// File: rtl/rb_window_sequencer.sv
// Raster-scans the image from external memory, writes each row into one of K
// circular BRAM row buffers and reads the other K-1 to form window columns.
module rb_window_sequencer
  import rb_pkg::*;
#(
  parameter int IMG_W  = RB_IMG_W,
  parameter int IMG_H  = RB_IMG_H,
  parameter int K      = RB_K,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int EXT_AW = $clog2(IMG_W * IMG_H),
  parameter int ROW_SW = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              ext_rd_en,
  output logic [EXT_AW-1:0] ext_rd_addr,
  output logic [K-1:0]      bram_we,
  output logic [COL_W-1:0]  bram_wr_addr,
  output logic              bram_rd_en,
  output logic [COL_W-1:0]  bram_rd_addr,
  output logic [ROW_SW-1:0] row_oldest,
  output logic              col_valid,
  output logic              col_first,
  output logic              col_last
);

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int S2_N  = RB_RD_LAT;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_WIN = ROW_W'(K - 1);

  rb_state_e r_state, w_state_nxt;

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [EXT_AW-1:0] r_addr;

  logic              w_issue, w_accept, w_last_pix, w_drained;
  logic [K-1:0]      w_onehot;
  logic [ROW_SW-1:0] w_oldest;

  logic              r_s1_valid, r_s1_win;
  logic [COL_W-1:0]  r_s1_col;
  logic [K-1:0]      r_s1_we;
  logic [ROW_SW-1:0] r_s1_oldest;

  logic              r_s2_valid  [S2_N];
  logic              r_s2_first  [S2_N];
  logic              r_s2_last   [S2_N];
  logic [ROW_SW-1:0] r_s2_oldest [S2_N];

  assign w_issue    = (r_state == ST_RUN) && !stall;
  assign w_accept   = (r_state == ST_IDLE) && start && !stall;
  assign w_last_pix = (r_col == COL_MAX) && (r_row == ROW_MAX);

  // Exit DRAIN when S1 is empty; the last column leaves S2 on this same edge.
  always_comb begin
    w_drained = !r_s1_valid;
    for (int i = 0; i < S2_N - 1; i++) begin
      if (r_s2_valid[i]) w_drained = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!stall) begin
      unique case (r_state)
        ST_IDLE:  if (start)      w_state_nxt = ST_RUN;
        ST_RUN:   if (w_last_pix) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drained)  w_state_nxt = ST_DONE;
        ST_DONE:                  w_state_nxt = ST_IDLE;
        default:                  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      r_addr <= r_addr + EXT_AW'(1);
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  rb_row_rotator #(
    .K      (K),
    .ROW_SW (ROW_SW)
  ) u_rotator (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_advance (w_issue && (r_col == COL_MAX)),
    .o_onehot  (w_onehot),
    .o_oldest  (w_oldest)
  );

  // S1 aligns with external read data; S2 with BRAM read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_win    <= 1'b0;
      r_s1_col    <= '0;
      r_s1_we     <= '0;
      r_s1_oldest <= '0;
      for (int i = 0; i < S2_N; i++) begin
        r_s2_valid[i]  <= 1'b0;
        r_s2_first[i]  <= 1'b0;
        r_s2_last[i]   <= 1'b0;
        r_s2_oldest[i] <= '0;
      end
    end else if (!stall) begin
      r_s1_valid     <= w_issue;
      r_s1_win       <= (r_row >= ROW_WIN);
      r_s1_col       <= r_col;
      r_s1_we        <= w_onehot;
      r_s1_oldest    <= w_oldest;
      r_s2_valid[0]  <= r_s1_valid && r_s1_win;
      r_s2_first[0]  <= (r_s1_col == '0);
      r_s2_last[0]   <= (r_s1_col == COL_MAX);
      r_s2_oldest[0] <= r_s1_oldest;
      for (int i = 1; i < S2_N; i++) begin
        r_s2_valid[i]  <= r_s2_valid[i-1];
        r_s2_first[i]  <= r_s2_first[i-1];
        r_s2_last[i]   <= r_s2_last[i-1];
        r_s2_oldest[i] <= r_s2_oldest[i-1];
      end
    end
  end

  // Strobes drop during stall; addresses stay visible so nothing is lost.
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE) && !stall;
  assign ext_rd_en    = w_issue;
  assign ext_rd_addr  = (r_state == ST_RUN) ? r_addr : '0;
  assign bram_we      = (r_s1_valid && !stall) ? r_s1_we : '0;
  assign bram_wr_addr = r_s1_valid ? r_s1_col : '0;
  assign bram_rd_en   = r_s1_valid && r_s1_win && !stall;
  assign bram_rd_addr = (r_s1_valid && r_s1_win) ? r_s1_col : '0;
  assign col_valid    = r_s2_valid[S2_N-1] && !stall;
  assign col_first    = col_valid && r_s2_first[S2_N-1];
  assign col_last     = col_valid && r_s2_last[S2_N-1];
  assign row_oldest   = r_s2_valid[S2_N-1] ? r_s2_oldest[S2_N-1] : '0;

endmodule

// File: tb/tb_rb_window_sequencer.sv
// Directed scenarios plus random stall/start/reset traffic, checked every
// cycle against a frame-progress model and against fixed frame timings.
module tb_rb_window_sequencer;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int K      = 3;
  localparam int N      = W * H;
  localparam int COL_W  = $clog2(W);
  localparam int EXT_AW = $clog2(N);
  localparam int ROW_SW = $clog2(K);

  logic              clk = 1'b0;
  logic              rst, start, stall;
  logic              busy, done, ext_rd_en, bram_rd_en;
  logic              col_valid, col_first, col_last;
  logic [EXT_AW-1:0] ext_rd_addr;
  logic [K-1:0]      bram_we;
  logic [COL_W-1:0]  bram_wr_addr, bram_rd_addr;
  logic [ROW_SW-1:0] row_oldest;

  always #5 clk = ~clk;

  rb_window_sequencer #(
    .IMG_W (W),
    .IMG_H (H),
    .K     (K)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .ext_rd_en    (ext_rd_en),
    .ext_rd_addr  (ext_rd_addr),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_rd_en   (bram_rd_en),
    .bram_rd_addr (bram_rd_addr),
    .row_oldest   (row_oldest),
    .col_valid    (col_valid),
    .col_first    (col_first),
    .col_last     (col_last)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: a frame is a count m_t of non-stalled cycles since start acceptance.
  // Pixel m_t is issued, m_t-1 is at the write stage, m_t-2 at the window stage.
  bit m_active = 1'b0;
  int m_t      = 0;

  int s_start, s_rd, s_cv, s_first_rd, s_first_cv, s_last_cv;
  int s_done_cnt, s_done_first, s_rd_after;
  int oldest_seq[$];
  int exp_old[4] = '{0, 1, 2, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic begin_scn();
    s_rd = 0; s_cv = 0; s_first_rd = -1; s_first_cv = -1; s_last_cv = -1;
    s_done_cnt = 0; s_done_first = -1; s_rd_after = -1;
    oldest_seq.delete();
    s_start = cyc;
  endtask

  task automatic run_cycle(input logic i_start, input logic i_stall, input logic i_rst);
    int  e_en, e_addr, e_we, e_wa, e_rden, e_ra, e_old, e_cv, e_first, e_last, e_busy, e_done;
    int  p, r, c;
    bit  act;
    start = i_start;
    stall = i_stall;
    rst   = i_rst;
    @(negedge clk);
    e_en = 0; e_addr = 0; e_we = 0; e_wa = 0; e_rden = 0; e_ra = 0;
    e_old = 0; e_cv = 0; e_first = 0; e_last = 0; e_busy = 0; e_done = 0;
    act = !i_stall;
    if (m_active) begin
      e_busy = 1;
      if (m_t < N) begin
        e_addr = m_t;
        e_en   = act ? 1 : 0;
      end
      p = m_t - 1;
      if (p >= 0 && p < N) begin
        r    = p / W;
        c    = p % W;
        e_wa = c;
        e_we = act ? (1 << (r % K)) : 0;
        if (r >= K - 1) begin
          e_ra   = c;
          e_rden = act ? 1 : 0;
        end
      end
      p = m_t - 2;
      if (p >= 0 && p < N && (p / W) >= K - 1) begin
        r       = p / W;
        c       = p % W;
        e_old   = (r + 1) % K;
        e_cv    = act ? 1 : 0;
        e_first = (act && c == 0) ? 1 : 0;
        e_last  = (act && c == W - 1) ? 1 : 0;
      end
      e_done = (act && m_t == N + 2) ? 1 : 0;
    end
    check("busy",         32'(busy),         e_busy);
    check("done",         32'(done),         e_done);
    check("ext_rd_en",    32'(ext_rd_en),    e_en);
    check("ext_rd_addr",  32'(ext_rd_addr),  e_addr);
    check("bram_we",      32'(bram_we),      e_we);
    check("bram_wr_addr", 32'(bram_wr_addr), e_wa);
    check("bram_rd_en",   32'(bram_rd_en),   e_rden);
    check("bram_rd_addr", 32'(bram_rd_addr), e_ra);
    check("row_oldest",   32'(row_oldest),   e_old);
    check("col_valid",    32'(col_valid),    e_cv);
    check("col_first",    32'(col_first),    e_first);
    check("col_last",     32'(col_last),     e_last);
    if (ext_rd_en === 1'b1) begin
      if (s_rd == 0) s_first_rd = cyc;
      if (s_done_cnt > 0 && s_rd_after < 0) s_rd_after = cyc;
      s_rd++;
    end
    if (col_valid === 1'b1) begin
      if (s_cv == 0) s_first_cv = cyc;
      s_last_cv = cyc;
      s_cv++;
      if (col_first === 1'b1) oldest_seq.push_back(int'(row_oldest));
    end
    if (done === 1'b1) begin
      if (s_done_cnt == 0) s_done_first = cyc;
      s_done_cnt++;
    end
    @(posedge clk);
    if (i_rst) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (!m_active) begin
      if (i_start && !i_stall) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (!i_stall) begin
      if (m_t == N + 2) m_active = 1'b0;
      else              m_t++;
    end
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;

    // Reset state
    run_cycle(1'b0, 1'b0, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0);

    // Nominal frame
    begin_scn();
    run_cycle(1'b1, 1'b0, 1'b0);
    repeat (60) run_cycle(1'b0, 1'b0, 1'b0);
    check("nom_reads",      s_rd, N);
    check("nom_first_rd",   s_first_rd - s_start, 1);
    check("nom_cv_count",   s_cv, 32);
    check("nom_first_cv",   s_first_cv - s_start, 19);
    check("nom_last_cv",    s_last_cv - s_start, 50);
    check("nom_done_cycle", s_done_first - s_start, 51);
    check("nom_done_count", s_done_cnt, 1);
    check("nom_oldest_len", oldest_seq.size(), 4);
    for (int i = 0; i < 4 && i < oldest_seq.size(); i++) begin
      check("nom_oldest_row", oldest_seq[i], exp_old[i]);
    end

    // Stall window 20..24
    begin_scn();
    run_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 70; i++) run_cycle(1'b0, (i >= 20 && i <= 24), 1'b0);
    check("stall_reads",      s_rd, N);
    check("stall_cv_count",   s_cv, 32);
    check("stall_last_cv",    s_last_cv - s_start, 55);
    check("stall_done_cycle", s_done_first - s_start, 56);
    check("stall_done_count", s_done_cnt, 1);

    // start pulsed while busy
    begin_scn();
    run_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 70; i++) run_cycle(i == 30, 1'b0, 1'b0);
    check("busy_start_done_cycle", s_done_first - s_start, 51);
    check("busy_start_done_count", s_done_cnt, 1);
    check("busy_start_reads",      s_rd, N);

    // Reset mid-frame, then a clean frame
    begin_scn();
    run_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 25; i++) run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1);
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0);
    check("rst_reads",      s_rd, 25);
    check("rst_done_count", s_done_cnt, 0);
    begin_scn();
    run_cycle(1'b1, 1'b0, 1'b0);
    repeat (60) run_cycle(1'b0, 1'b0, 1'b0);
    check("post_rst_first_cv",   s_first_cv - s_start, 19);
    check("post_rst_done_cycle", s_done_first - s_start, 51);
    check("post_rst_cv_count",   s_cv, 32);

    // Back-to-back frames with start held high
    begin_scn();
    repeat (120) run_cycle(1'b1, 1'b0, 1'b0);
    repeat (60) run_cycle(1'b0, 1'b0, 1'b0);
    check("b2b_done_cycle",  s_done_first - s_start, 51);
    check("b2b_restart_gap", s_rd_after - s_done_first, 2);
    check("b2b_done_count",  s_done_cnt, 3);

    // Random stall / start / occasional reset traffic
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
